// File: rtl/inner_loop_sched.sv
// rtl/inner_loop_sched.sv - B-word sequencer for the inner-loop multiplier datapath (optional prefetch: INNER_SCHED_PREFETCH_EN)
module inner_loop_sched #(
    parameter int NUM_WORDS = 48,
    parameter int WORD_W    = 64,
    parameter int LAT       = 5,
    parameter int IDX_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              b_rd_en,
    output logic [IDX_W-1:0]  b_addr,
    input  logic [WORD_W-1:0] b_rdata,
    output logic [WORD_W-1:0] bi,
    output logic              ilp_en,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_idx,
    input  logic              acc_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int                CNT_W    = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LAT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   bi_q, bi_d;
    logic                is_last;

`ifdef INNER_SCHED_PREFETCH_EN
    // Shadow copy of the next B word, read while the datapath is busy with the current one.
    logic [WORD_W-1:0]   bi_nxt_q, bi_nxt_d;
    logic                pf_pend_q, pf_pend_d;
`endif

    assign is_last = (idx_q == LAST_IDX);
    assign bi      = bi_q;
    assign busy    = (state_q != S_IDLE);

    // Next-state, datapath bookkeeping and Moore-decoded outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bi_d      = bi_q;
        b_rd_en   = 1'b0;
        b_addr    = '0;
        ilp_en    = 1'b0;
        res_valid = 1'b0;
        res_idx   = '0;
        done      = 1'b0;
`ifdef INNER_SCHED_PREFETCH_EN
        bi_nxt_d  = bi_nxt_q;
        pf_pend_d = 1'b0;
        // Memory has one cycle of read latency; land the prefetched word in the shadow.
        if (pf_pend_q) begin
            bi_nxt_d = b_rdata;
        end
`endif

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start && !abort) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                b_rd_en = 1'b1;
                b_addr  = idx_q;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                bi_d    = b_rdata;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                ilp_en  = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef INNER_SCHED_PREFETCH_EN
                if (cnt_q == CNT_INIT && !is_last) begin
                    b_rd_en   = 1'b1;
                    b_addr    = idx_q + 1'b1;
                    pf_pend_d = 1'b1;
                end
`endif
                if (cnt_q == '0) begin
                    state_d = S_EMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EMIT: begin
                res_valid = 1'b1;
                res_idx   = idx_q;
                if (acc_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
`ifdef INNER_SCHED_PREFETCH_EN
                        // With LAT=1 the prefetch data arrives in this very cycle.
                        bi_d    = pf_pend_q ? b_rdata : bi_nxt_q;
                        state_d = S_ISSUE;
`else
                        state_d = S_FETCH;
`endif
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort beats everything outside IDLE; bi keeps the last word the datapath saw.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            bi_d    = bi_q;
`ifdef INNER_SCHED_PREFETCH_EN
            bi_nxt_d  = '0;
            pf_pend_d = 1'b0;
`endif
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            bi_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bi_q    <= bi_d;
        end
    end

`ifdef INNER_SCHED_PREFETCH_EN
    // Prefetch shadow register and its in-flight flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bi_nxt_q  <= '0;
            pf_pend_q <= 1'b0;
        end else begin
            bi_nxt_q  <= bi_nxt_d;
            pf_pend_q <= pf_pend_d;
        end
    end
`endif

endmodule
